// File: rtl/sb_1237_freq_gen_pkg.sv
// Shared types and constants for the sb_1237 square-wave frequency generator.
//   count_t        : half-period width in prescaled ticks
//   state_e        : generator FSM state (idle / high half / low half)
//   DefaultPrescale: default clk cycles per tick
package sb_1237_freq_gen_pkg;

  localparam int unsigned CountW          = 14;
  localparam int unsigned DefaultPrescale = 4;

  typedef logic [CountW-1:0] count_t;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } state_e;

endpackage

// File: rtl/sb_1237_freq_gen_if.sv
// Configuration handshake for sb_1237_freq_gen.
//   cfg_valid : a new half-period value is offered (master -> slave)
//   cfg_count : half-period in ticks, 0 means stop (master -> slave)
//   cfg_ready : slave can take a value this cycle (slave -> master)
interface sb_1237_freq_gen_if;
  import sb_1237_freq_gen_pkg::*;

  logic   cfg_valid;
  logic   cfg_ready;
  count_t cfg_count;

  modport master (
    output cfg_valid,
    output cfg_count,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_count,
    output cfg_ready
  );

endinterface

// File: rtl/sb_1237_tick_div.sv
// Free-running prescaler: counts 0..PRESCALE-1 and flags the wrap cycle.
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   tick_o : high for one clk each time the counter sits at PRESCALE-1
module sb_1237_tick_div
  import sb_1237_freq_gen_pkg::*;
#(
  parameter int unsigned PRESCALE = DefaultPrescale
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(PRESCALE);
  localparam logic [CntW-1:0] Wrap = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == Wrap) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == Wrap);

endmodule

// File: rtl/sb_1237_freq_gen.sv
// Programmable square-wave generator. Each half of the period lasts
// active_count prescaled ticks; new counts arrive through a one-deep pending
// register and only take effect at a period boundary.
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   enable      : allow starting / continuing periods
//   cfg         : half-period configuration handshake (slave side)
//   op_signal   : registered square-wave output
//   period_done : one-clk pulse at the end of each full period
//   busy        : FSM is not idle
module sb_1237_freq_gen
  import sb_1237_freq_gen_pkg::*;
#(
  parameter int unsigned PRESCALE = DefaultPrescale
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  sb_1237_freq_gen_if.slave        cfg,
  output logic                     op_signal,
  output logic                     period_done,
  output logic                     busy
);

  logic tick;

  sb_1237_tick_div #(
    .PRESCALE(PRESCALE)
  ) u_tick_div (
    .clk   (clk),
    .rst   (rst),
    .tick_o(tick)
  );

  state_e state_q, state_d;
  count_t tick_cnt_q, tick_cnt_d;
  count_t active_q, active_d;
  count_t pend_q, pend_d;
  logic   pend_full_q, pend_full_d;
  logic   op_signal_q, op_signal_d;
  logic   period_done_q, period_done_d;

  logic   accept;
  logic   last_tick;
  logic   boundary;
  logic   xfer;
  count_t next_count;

  assign cfg.cfg_ready = !pend_full_q;
  assign accept        = cfg.cfg_valid && !pend_full_q;
  assign last_tick     = tick && (tick_cnt_q == count_t'(1));

  // Count the next period would use: a waiting value wins over the current one.
  assign next_count = pend_full_q ? pend_q : active_q;

  // In idle a zero is dropped at once; a nonzero value waits for an enabled tick.
  assign boundary = ((state_q == StLow) && last_tick) ||
                    ((state_q == StIdle) && ((pend_q == '0) || (tick && enable)));
  assign xfer     = pend_full_q && boundary;

  // Handshake and pending/active registers.
  always_comb begin
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    active_d    = active_q;
    if (xfer) begin
      active_d    = pend_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_d      = cfg.cfg_count;
      pend_full_d = 1'b1;
    end
  end

  // Next-state and tick counter.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (tick && enable && (next_count != '0)) begin
          state_d    = StHigh;
          tick_cnt_d = next_count;
        end
      end
      StHigh: begin
        if (last_tick) begin
          state_d    = StLow;
          tick_cnt_d = active_q;
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q - count_t'(1);
        end
      end
      StLow: begin
        if (last_tick) begin
          if (enable && (next_count != '0)) begin
            state_d    = StHigh;
            tick_cnt_d = next_count;
          end else begin
            state_d    = StIdle;
            tick_cnt_d = '0;
          end
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q - count_t'(1);
        end
      end
      default: begin
        state_d    = StIdle;
        tick_cnt_d = '0;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    op_signal_d   = (state_d == StHigh);
    period_done_d = (state_q == StLow) && last_tick;
    busy          = (state_q != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      tick_cnt_q    <= '0;
      active_q      <= '0;
      pend_q        <= '0;
      pend_full_q   <= 1'b0;
      op_signal_q   <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      active_q      <= active_d;
      pend_q        <= pend_d;
      pend_full_q   <= pend_full_d;
      op_signal_q   <= op_signal_d;
      period_done_q <= period_done_d;
    end
  end

  assign op_signal   = op_signal_q;
  assign period_done = period_done_q;

endmodule

// File: tb/tb_sb_1237_freq_gen.sv
// Bench for sb_1237_freq_gen: a waveform monitor measures high/low widths and
// period_done spacing; expectations come from count * PRESCALE arithmetic.
module tb_sb_1237_freq_gen;

  localparam int unsigned P = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic op_signal, period_done, busy;

  int checks = 0;
  int errors = 0;

  sb_1237_freq_gen_if cfg_if ();

  sb_1237_freq_gen #(
    .PRESCALE(P)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .cfg        (cfg_if),
    .op_signal  (op_signal),
    .period_done(period_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Waveform monitor: widths measured in clk cycles at the negative edge.
  int hi_q[$];
  int lo_q[$];
  int lo_idle_q[$];
  int pd_q[$];
  int pd_wide = 0;

  initial begin
    int  hi_cnt = 0, lo_cnt = 0, pd_cnt = 0;
    bit  prev_op = 0, prev_pd = 0, seen_fall = 0, seen_pd = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hi_cnt = 0; lo_cnt = 0; pd_cnt = 0;
        prev_op = 0; prev_pd = 0; seen_fall = 0; seen_pd = 0;
      end else begin
        if (period_done) begin
          if (prev_pd) pd_wide++;
          if (seen_pd) pd_q.push_back(pd_cnt);
          if (!op_signal && seen_fall) lo_idle_q.push_back(lo_cnt);
          pd_cnt  = 0;
          seen_pd = 1;
        end
        pd_cnt++;
        if (op_signal) begin
          if (!prev_op) begin
            if (seen_fall) lo_q.push_back(lo_cnt);
            hi_cnt = 0;
          end
          hi_cnt++;
        end else begin
          if (prev_op) begin
            hi_q.push_back(hi_cnt);
            seen_fall = 1;
            lo_cnt    = 0;
          end
          lo_cnt++;
        end
        prev_op = op_signal;
        prev_pd = period_done;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    hi_q.delete();
    lo_q.delete();
    lo_idle_q.delete();
    pd_q.delete();
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    enable           = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_count = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_q();
  endtask

  task automatic send_cfg(input logic [13:0] v);
    int n = 0;
    while (!cfg_if.cfg_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_count = v;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
  endtask

  // which: 0 high width, 1 low width, 2 period_done gap, 3 low width before idle
  task automatic pop_q(input int which, input int limit, output int v);
    int n = 0;
    v = -1;
    forever begin
      if (which == 0 && hi_q.size() > 0) begin v = hi_q.pop_front(); break; end
      if (which == 1 && lo_q.size() > 0) begin v = lo_q.pop_front(); break; end
      if (which == 2 && pd_q.size() > 0) begin v = pd_q.pop_front(); break; end
      if (which == 3 && lo_idle_q.size() > 0) begin v = lo_idle_q.pop_front(); break; end
      if (n >= limit) break;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_op(input logic lvl, input int limit, output int ok);
    int n = 0;
    while (op_signal !== lvl && n < limit) begin
      @(negedge clk);
      n++;
    end
    ok = (op_signal === lvl) ? 1 : 0;
  endtask

  initial begin
    int v, ok, seen, n;

    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_count = '0;
    repeat (2) @(negedge clk);
    chk("rst_op_signal", int'(op_signal), 0);
    chk("rst_period_done", int'(period_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cfg_ready", int'(cfg_if.cfg_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cfg_ready", int'(cfg_if.cfg_ready), 1);

    // Zero count only: nothing starts, pending is dropped.
    do_reset();
    enable = 1'b1;
    send_cfg(14'd0);
    @(negedge clk);
    chk("zero_cfg_ready", int'(cfg_if.cfg_ready), 1);
    seen = 0;
    repeat (3 * P) begin
      @(negedge clk);
      if (op_signal || busy) seen++;
    end
    chk("zero_stays_idle", seen, 0);

    // Count 5: 20/20 clk, period_done every 40 clk as single pulses.
    do_reset();
    send_cfg(14'd5);
    enable = 1'b1;
    pop_q(0, 200, v); chk("c5_high", v, 5 * P);
    pop_q(1, 200, v); chk("c5_low", v, 5 * P);
    pop_q(2, 200, v); chk("c5_pd_gap", v, 2 * 5 * P);
    pop_q(0, 200, v); chk("c5_high2", v, 5 * P);

    // Count 2 accepted mid-HIGH of a count-5 period.
    do_reset();
    send_cfg(14'd5);
    enable = 1'b1;
    wait_op(1'b1, 100, ok);
    chk("chg_start", ok, 1);
    clear_q();
    repeat (3) @(negedge clk);
    send_cfg(14'd2);
    chk("chg_ready_after_accept", int'(cfg_if.cfg_ready), 0);
    pop_q(0, 200, v); chk("chg_high_cur", v, 5 * P);
    chk("chg_ready_in_low", int'(cfg_if.cfg_ready), 0);
    pop_q(1, 200, v); chk("chg_low_cur", v, 5 * P);
    chk("chg_ready_after_boundary", int'(cfg_if.cfg_ready), 1);
    pop_q(0, 200, v); chk("chg_high_next", v, 2 * P);
    pop_q(1, 200, v); chk("chg_low_next", v, 2 * P);

    // Enable dropped during HIGH at count 3: period completes, then idle.
    do_reset();
    send_cfg(14'd3);
    enable = 1'b1;
    wait_op(1'b1, 100, ok);
    chk("dis_start", ok, 1);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    pop_q(0, 200, v); chk("dis_high", v, 3 * P);
    pop_q(3, 200, v); chk("dis_low", v, 3 * P);
    @(negedge clk);
    chk("dis_busy", int'(busy), 0);
    seen = 0;
    repeat (4 * P) begin
      @(negedge clk);
      if (op_signal) seen++;
    end
    chk("dis_no_restart", seen, 0);

    // Reset mid-HIGH at count 100.
    do_reset();
    send_cfg(14'd100);
    enable = 1'b1;
    wait_op(1'b1, 100, ok);
    repeat (50) @(negedge clk);
    chk("rst_mid_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_op_signal", int'(op_signal), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_period_done", int'(period_done), 0);
    chk("rst_mid_cfg_ready", int'(cfg_if.cfg_ready), 1);
    repeat (2) @(negedge clk);

    // Random counts against count * PRESCALE.
    for (int i = 0; i < 3; i++) begin
      n = int'($urandom_range(1, 9));
      do_reset();
      send_cfg(14'(n));
      enable = 1'b1;
      pop_q(0, 400, v); chk($sformatf("rnd%0d_high_n%0d", i, n), v, n * P);
      pop_q(1, 400, v); chk($sformatf("rnd%0d_low_n%0d", i, n), v, n * P);
      pop_q(2, 400, v); chk($sformatf("rnd%0d_pd_gap_n%0d", i, n), v, 2 * n * P);
    end
    chk("pd_single_cycle", pd_wide, 0);

    // Maximum count: high time must not wrap early.
    do_reset();
    send_cfg(14'd16383);
    enable = 1'b1;
    pop_q(0, 70000, v); chk("max_high", v, 16383 * P);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sb_1237_freq_gen.md
SB_1237_FREQ_GEN -- requirements
Module: sb_1237_freq_gen

Interface
REQ-001 SHALL have parameter PRESCALE, default 4, meaning clk cycles per tick; legal range 2..256.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1; when high, the block may start and continue periods.
REQ-005 SHALL have port cfg_valid, input, 1; a new half-period value is offered.
REQ-006 SHALL have port cfg_ready, output, 1; the block can accept a value this cycle.
REQ-007 SHALL have port cfg_count, input, 14; the half-period in ticks; 0 means stop.
REQ-008 SHALL have port op_signal, output, 1; the generated square wave, registered.
REQ-009 SHALL have port period_done, output, 1; a one-clk pulse at the end of each full period.
REQ-010 SHALL have port busy, output, 1; high whenever the state is not IDLE.

Function
REQ-011 SHALL divide clk with a prescaler counter that wraps at PRESCALE-1 and asserts tick for one clk at each wrap; the counter free-runs from reset.
REQ-012 SHALL accept cfg_count into a pending register on any clk with cfg_valid && cfg_ready, and set pend_full.
REQ-013 SHALL drive cfg_ready = !pend_full; a second value is not accepted until pending transfers.
REQ-014 SHALL transfer pending to the active register, clearing pend_full, only at a period boundary: in IDLE, or on the tick that ends LOW.
REQ-015 SHALL accept a new value on the same clk that pending transfers, if cfg_valid is high and pend_full was clear before that edge.
REQ-016 SHALL implement the FSM IDLE -> HIGH -> LOW -> (HIGH | IDLE).
REQ-017 IDLE: op_signal=0; on a tick with enable=1 and a transferable nonzero count, go to HIGH, set op_signal=1, and load the tick counter.
REQ-018 HIGH: op_signal=1 for exactly active_count ticks, which is active_count*PRESCALE clk; then go to LOW with op_signal=0.
REQ-019 LOW: op_signal=0 for exactly active_count ticks. At its last tick, pulse period_done, then:
  - go to HIGH if enable=1 and the next active count is nonzero;
  - otherwise go to IDLE.
REQ-020 SHALL, when the transferred count is 0, go to IDLE at the boundary; in IDLE, a zero count is discarded and pend_full is cleared.
REQ-021 SHALL always complete the current full period when enable falls mid-period; no truncated pulses.
REQ-022 SHALL hold active_count unchanged mid-period; a value accepted mid-period applies from the next period.
REQ-023 SHALL use a 14-bit tick counter with no overflow; the maximum half-period is 16383 ticks.
REQ-024 SHALL produce output that the frequency counter at the receiving end measures as the programmed value, i.e. the high time equals cfg_count counted at the same prescaled rate.

Reset
REQ-025 SHALL, on rst, asynchronously force all of the following:
  - state=IDLE;
  - op_signal=0, period_done=0, busy=0;
  - pend_full=0, so cfg_ready=1 on the first clk after release;
  - active and pending registers to 0;
  - prescaler and tick counter to 0.
REQ-026 SHALL, on reset asserted mid-HIGH, drop op_signal low immediately, with no completion of the period.

Structure
REQ-027 SHALL place in a shared package: the FSM state enum (IDLE, HIGH, LOW), the count width constant 14, and the default PRESCALE.
REQ-028 SHALL instantiate one sub-module, sb_1237_tick_div, containing the prescaler and producing tick.
REQ-029 SHALL keep the FSM, the handshake and the counters in the top module.

Verification
REQ-030 cfg_count=5, enable=1, PRESCALE=4 -> op_signal high 20 clk, low 20 clk, repeating; period_done pulses every 40 clk.
REQ-031 cfg_count=0 only -> op_signal stays 0, busy=0, cfg_ready returns to 1 on the next clk.
REQ-032 running at 5, then cfg_count=2 accepted mid-HIGH -> current period remains 20/20 clk, next period is 8/8 clk; cfg_ready is 0 from acceptance until the boundary.
REQ-033 running at 3, enable deasserted during HIGH -> period finishes 12/12 clk, period_done pulses, state returns to IDLE, busy=0.
REQ-034 rst pulsed mid-HIGH at count 100 -> op_signal=0 immediately, and every output is at its reset value.
REQ-035 cfg_count=16383 -> high time is exactly 65532 clk; the counter does not wrap early.
